unsigned_restoring_divider: RTL and testbench
=============================================

UNSIGNED_RESTORING_DIVIDER -- requirements
Module: unsigned_restoring_divider

Interface
REQ-001 Parameter WIDTH, default 8: divisor/remainder width; dividend/quotient width is 2*WIDTH.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 dividend  input  2*WIDTH  unsigned numerator; sampled with start.
REQ-006 divisor  input  WIDTH  unsigned denominator; sampled with start.
REQ-007 busy  output  1  high while an operation is in progress, i.e. in state CALC.
REQ-008 done  output  1  one-cycle pulse; results are valid.
REQ-009 quotient  output  2*WIDTH  registered quotient.
REQ-010 remainder  output  WIDTH  registered remainder.
REQ-011 div_by_zero  output  1  registered flag; divisor was 0 for the last operation.

Function
REQ-012 FSM states IDLE, CALC, DONE; transitions: IDLE->CALC on start with divisor!=0; IDLE->DONE on start with divisor==0; CALC->DONE after 16 (2*WIDTH) CALC edges; DONE->IDLE unconditionally after one cycle.
REQ-013 Acceptance edge N: start=1 in IDLE latches dividend and divisor into internal registers; later input changes have no effect.
REQ-014 Algorithm: restoring shift-subtract, one quotient bit per CALC cycle, MSB first; partial remainder held in WIDTH+1 bits.
REQ-015 Each CALC step: shift the next dividend bit into the partial remainder, trial-subtract the divisor; if the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
REQ-016 Latency for a nonzero divisor: CALC covers edges N+1..N+2*WIDTH; outputs are updated at edge N+2*WIDTH; done=1 in the cycle after that edge (16 cycles after acceptance for WIDTH=8).
REQ-017 Divisor zero: at edge N set quotient=all ones, remainder=dividend[WIDTH-1:0], div_by_zero=1; done=1 in the cycle after edge N.
REQ-018 Nonzero divisor: div_by_zero=0 when results are written.
REQ-019 quotient, remainder and div_by_zero hold their values from done until the next result write or reset.
REQ-020 busy=0 in IDLE and DONE; busy=1 in CALC.
REQ-021 start is ignored in CALC and DONE; there is no queuing.
REQ-022 Arithmetic: quotient*divisor+remainder==dividend and remainder<divisor for every nonzero divisor; no overflow is possible.
REQ-023 done is never asserted in two consecutive cycles.

Reset
REQ-024 rst=1 at an edge: state=IDLE; busy, done, div_by_zero=0; quotient and remainder=0; step counter and internal registers=0.
REQ-025 rst has priority over start and over any in-progress CALC; an aborted operation produces no done and no result update.
REQ-026 After rst deasserts, the first start is accepted normally on the next edge.

Structure
REQ-027 The shared package/include holds the state encoding constants (IDLE, CALC, DONE) and the default WIDTH; the counter width is derived as clog2(2*WIDTH+1).
REQ-028 Sub-module div_step (combinational): inputs partial remainder, next dividend bit and divisor; outputs the new partial remainder and the quotient bit. The top level holds the FSM, counter and registers.

Verification
REQ-029 1000/7 (16'd1000, 8'd7) -> quotient=142, remainder=6, div_by_zero=0; done is a single pulse 16 cycles after acceptance.
REQ-030 16'hFFFF/8'hFF -> quotient=16'h0101, remainder=0; 16'hFFFF/8'h01 -> quotient=16'hFFFF, remainder=0.
REQ-031 5/9 -> quotient=0, remainder=5; 16'h0000/8'h03 -> quotient=0, remainder=0.
REQ-032 16'h1234/8'h00 -> quotient=16'hFFFF, remainder=8'h34, div_by_zero=1; done 1 cycle after acceptance; busy never high.
REQ-033 start pulsed with other operands during CALC and during DONE -> ignored; results match the first operands; a start in the following IDLE is accepted.
REQ-034 rst asserted at step 8 of 1000/7 -> outputs 0 and IDLE next cycle, no done; 200/3 started after reset -> quotient=66, remainder=2.

Source files
------------

// File: rtl/unsigned_restoring_divider_pkg.sv
// unsigned_restoring_divider_pkg: shared width default and FSM state encoding
package unsigned_restoring_divider_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/unsigned_restoring_divider_if.sv
// unsigned_restoring_divider_if: request/result bundle between requester and divider
interface unsigned_restoring_divider_if
    import unsigned_restoring_divider_pkg::*;
    #(parameter int WIDTH = DEF_WIDTH);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;
    modport master (output start, dividend, divisor,
                    input busy, done, quotient, remainder, div_by_zero);
    modport slave (input start, dividend, divisor,
                   output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/unsigned_restoring_divider_div_step.sv
// div_step: one restoring shift/trial-subtract step producing one quotient bit
module div_step #(parameter int WIDTH = 8) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {2'b00, divisor_i};
        q_o     = ~diff[WIDTH+1];
        rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];
    end
endmodule

// File: rtl/unsigned_restoring_divider.sv
// unsigned_restoring_divider: multi-cycle 2W/W unsigned divider, one quotient bit per cycle
module unsigned_restoring_divider
    import unsigned_restoring_divider_pkg::*;
    #(parameter int WIDTH = DEF_WIDTH) (
    input logic clk,
    input logic rst,
    unsigned_restoring_divider_if.slave bus
);
    localparam int N  = 2 * WIDTH;
    localparam int CW = $clog2(2 * WIDTH + 1);
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d, step_rem;
    logic             step_bit;
    logic [N-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i(rem_q), .bit_i(dq_q[N-1]), .divisor_i(dvs_q),
        .rem_o(step_rem), .q_o(step_bit)
    );
    // dq_q shifts dividend bits out the top while quotient bits fill in from the bottom
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (bus.start) begin
                dq_d  = bus.dividend;
                dvs_d = bus.divisor;
                rem_d = '0;
                cnt_d = '0;
                if (bus.divisor == '0) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rmd_d   = bus.dividend[WIDTH-1:0];
                    dbz_d   = 1'b1;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                dq_d  = {dq_q[N-2:0], step_bit};
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    quo_d   = {dq_q[N-2:0], step_bit};
                    rmd_d   = step_rem[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d == CALC;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_unsigned_restoring_divider.sv
// tb_unsigned_restoring_divider: vector table plus scoreboard checks for the divider
module tb_unsigned_restoring_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    unsigned_restoring_divider_if #(.WIDTH(8)) bus ();
    unsigned_restoring_divider #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } vec_t;
    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } exp_t;
    vec_t vecs[10];
    exp_t sb[$];
    int total = 0;
    int passed = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic start_op(input logic [15:0] dd, input logic [7:0] dv,
                            input logic [15:0] q, input logic [7:0] r, input logic z);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        sb.push_back('{q: q, r: r, z: z});
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
    endtask
    // entered at the sample right after the acceptance edge; n counts edges since then
    task automatic wait_done(input int lat, input int poke_at, input bit poke_done);
        int n = 0;
        exp_t e;
        chk("busy_after_accept", {31'd0, bus.busy}, lat > 0);
        while (!bus.done && n < 40) begin
            if (n == poke_at) begin
                bus.start    = 1'b1;
                bus.dividend = 16'h0100;
                bus.divisor  = 8'h01;
            end
            @(negedge clk);
            bus.start = 1'b0;
            n++;
        end
        chk("done_latency", n, lat);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            e = '{q: 16'h0, r: 8'h0, z: 1'b0};
        end else begin
            e = sb.pop_front();
        end
        chk("quotient", {16'd0, bus.quotient}, {16'd0, e.q});
        chk("remainder", {24'd0, bus.remainder}, {24'd0, e.r});
        chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.z});
        if (poke_done) begin
            bus.start    = 1'b1;
            bus.dividend = 16'h0100;
            bus.divisor  = 8'h01;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_single_pulse", {31'd0, bus.done}, 0);
        chk("busy_after_done", {31'd0, bus.busy}, 0);
        @(negedge clk);
        chk("quotient_hold", {16'd0, bus.quotient}, {16'd0, e.q});
        chk("remainder_hold", {24'd0, bus.remainder}, {24'd0, e.r});
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [15:0] dd;
        logic [7:0]  dv;
        int done_seen;
        vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,    1'b0};
        vecs[1] = '{16'hFFFF,  8'hFF,  16'h0101,  8'h00,   1'b0};
        vecs[2] = '{16'hFFFF,  8'h01,  16'hFFFF,  8'h00,   1'b0};
        vecs[3] = '{16'd5,     8'd9,   16'd0,     8'd5,    1'b0};
        vecs[4] = '{16'h0000,  8'h03,  16'h0000,  8'h00,   1'b0};
        vecs[5] = '{16'h1234,  8'h00,  16'hFFFF,  8'h34,   1'b1};
        vecs[6] = '{16'd200,   8'd3,   16'd66,    8'd2,    1'b0};
        vecs[7] = '{16'hFFFF,  8'h02,  16'h7FFF,  8'h01,   1'b0};
        vecs[8] = '{16'h8000,  8'h80,  16'h0100,  8'h00,   1'b0};
        vecs[9] = '{16'h00FF,  8'h10,  16'h000F,  8'h0F,   1'b0};
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 0);
        chk("reset_done", {31'd0, bus.done}, 0);
        chk("reset_quotient", {16'd0, bus.quotient}, 0);
        chk("reset_remainder", {24'd0, bus.remainder}, 0);
        chk("reset_dbz", {31'd0, bus.div_by_zero}, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r, vecs[i].z);
            wait_done(vecs[i].dv == 8'd0 ? 0 : 16, i == 0 ? 5 : -1, i == 0);
        end
        for (int i = 0; i < 6; i++) begin
            dd = 16'($urandom);
            dv = (i == 5) ? 8'd0 : 8'($urandom_range(1, 255));
            if (dv == 8'd0) start_op(dd, dv, 16'hFFFF, dd[7:0], 1'b1);
            else start_op(dd, dv, dd / {8'd0, dv}, 8'(dd % {8'd0, dv}), 1'b0);
            wait_done(dv == 8'd0 ? 0 : 16, -1, 1'b0);
        end
        start_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("abort_busy", {31'd0, bus.busy}, 0);
        chk("abort_done", {31'd0, bus.done}, 0);
        chk("abort_quotient", {16'd0, bus.quotient}, 0);
        chk("abort_remainder", {24'd0, bus.remainder}, 0);
        chk("abort_dbz", {31'd0, bus.div_by_zero}, 0);
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        start_op(16'd200, 8'd3, 16'd66, 8'd2, 1'b0);
        wait_done(16, -1, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
